// File: rtl/reg_write_pkg.sv
// Shared types and helpers for the reg_write_seq register-bank write initiator.
package reg_write_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, no bypass, full/empty derived from an occupancy counter.
module reg_cmd_fifo
  import reg_write_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is never read while empty, so it carries no reset; only the pointers and count do.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_write_seq.sv
// Write-side initiator for a bank of gen_reg instances: queues (addr, data) commands and issues
// data + one-hot strobe transactions. Define REG_SHADOW_EN to add a readable shadow of written values.
module reg_write_seq
  import reg_write_pkg::*;
#(
  parameter int DATA_WIDTH    = 12,
  parameter int NUM_REGS      = 4,
  parameter int ADDR_WIDTH    = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic [DATA_WIDTH-1:0] reg_data_out,
  output logic [NUM_REGS-1:0]   reg_wrt,
  output logic                  busy,
  output logic                  err_addr
`ifdef REG_SHADOW_EN
  ,
  input  logic [ADDR_WIDTH-1:0] shadow_addr,
  output logic [DATA_WIDTH-1:0] shadow_data
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } cmd_t;

  localparam int                  CNT_W      = (SETTLE_CYCLES > 1) ? clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD   = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  state_t                state, state_next;
  cmd_t                  push_cmd, head;
  logic                  fifo_full, fifo_empty;
  logic                  pop, load, bad, dispatch, head_bad;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt;

  assign push_cmd  = '{addr: cmd_addr, data: cmd_data};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign head_bad  = ({1'b0, head.addr} >= NUM_REGS_W);

  reg_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (cmd_valid),
    .pop  (pop),
    .wdata(push_cmd),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    dispatch   = 1'b0;
    pop        = 1'b0;
    load       = 1'b0;
    bad        = 1'b0;
    case (state)
      IDLE:    dispatch = 1'b1;
      SETUP:   state_next = STROBE;
      STROBE:  if (SETTLE_CYCLES == 0) dispatch = 1'b1; else state_next = HOLD;
      HOLD:    if (cnt == '0) dispatch = 1'b1;
      default: state_next = IDLE;
    endcase
    // A command whose address has no register is consumed and flagged without touching the bus.
    if (dispatch) begin
      state_next = IDLE;
      if (!fifo_empty) begin
        pop = 1'b1;
        if (head_bad) begin
          bad = 1'b1;
        end else begin
          load       = 1'b1;
          state_next = SETUP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      reg_data_out <= '0;
      addr_q       <= '0;
      reg_wrt      <= '0;
      err_addr     <= 1'b0;
      cnt          <= '0;
    end else begin
      state    <= state_next;
      err_addr <= bad;
      reg_wrt  <= (state_next == STROBE) ? (NUM_REGS'(1) << addr_q) : '0;
      if (load) begin
        reg_data_out <= head.data;
        addr_q       <= head.addr;
      end
      if (state == STROBE && state_next == HOLD) cnt <= CNT_LOAD;
      else if (state == HOLD && cnt != '0)       cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef REG_SHADOW_EN
  localparam int IDX_W = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (state_next == STROBE) begin
      shadow[addr_q[IDX_W-1:0]] <= reg_data_out;
    end
  end

  assign shadow_data = ({1'b0, shadow_addr} < NUM_REGS_W) ? shadow[shadow_addr[IDX_W-1:0]] : '0;
`endif

endmodule

// File: tb/tb_reg_write_seq.sv
// Self-checking bench for reg_write_seq: directed scenarios plus a randomized run against a
// timing-level reference model. Two instances: SETTLE_CYCLES=2 (3-bit addr) and SETTLE_CYCLES=0.
module tb_reg_write_seq;

  localparam int DW    = 12;
  localparam int NR    = 4;
  localparam int AW    = 3;
  localparam int AW0   = 2;
  localparam int DEPTH = 4;
  localparam int S     = 2;
  localparam int S0    = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic          cmd_valid = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_data  = '0;
  logic          cmd_ready;
  logic [DW-1:0] reg_data_out;
  logic [NR-1:0] reg_wrt;
  logic          busy, err_addr;

  logic           cmd_valid0 = 1'b0;
  logic [AW0-1:0] cmd_addr0  = '0;
  logic [DW-1:0]  cmd_data0  = '0;
  logic           cmd_ready0;
  logic [DW-1:0]  reg_data_out0;
  logic [NR-1:0]  reg_wrt0;
  logic           busy0, err_addr0;

`ifdef REG_SHADOW_EN
  logic [AW-1:0]  shadow_addr  = '0;
  logic [DW-1:0]  shadow_data;
  logic [AW0-1:0] shadow_addr0 = '0;
  logic [DW-1:0]  shadow_data0;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  reg_write_seq #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .reg_data_out(reg_data_out),
    .reg_wrt(reg_wrt), .busy(busy), .err_addr(err_addr)
`ifdef REG_SHADOW_EN
    , .shadow_addr(shadow_addr), .shadow_data(shadow_data)
`endif
  );

  reg_write_seq #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW0), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(S0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_addr(cmd_addr0), .cmd_data(cmd_data0), .reg_data_out(reg_data_out0),
    .reg_wrt(reg_wrt0), .busy(busy0), .err_addr(err_addr0)
`ifdef REG_SHADOW_EN
    , .shadow_addr(shadow_addr0), .shadow_data(shadow_data0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    cmd_valid  = 1'b0;
    cmd_valid0 = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({reg_data_out, reg_wrt, busy, err_addr, cmd_ready} !== {12'h000, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got data=%h wrt=%b busy=%b err=%b rdy=%b expected 000 0000 0 0 1",
               reg_data_out, reg_wrt, busy, err_addr, cmd_ready);
    end
    checks++;
    if ({reg_data_out0, reg_wrt0, busy0, err_addr0, cmd_ready0} !== {12'h000, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state0: got data=%h wrt=%b busy=%b err=%b rdy=%b expected 000 0000 0 0 1",
               reg_data_out0, reg_wrt0, busy0, err_addr0, cmd_ready0);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    cmd_valid = 1'b1; cmd_addr = 3'd2; cmd_data = 12'hABC;
    tick();  // T: accepted
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || reg_data_out !== 12'h000) begin
      fails++; $display("FAIL single_T: got busy=%b data=%h expected 1 000", busy, reg_data_out);
    end
    tick();  // T+1
    checks++;
    if (reg_data_out !== 12'hABC || reg_wrt !== 4'b0000) begin
      fails++; $display("FAIL single_T1: got data=%h wrt=%b expected abc 0000", reg_data_out, reg_wrt);
    end
    tick();  // T+2
    checks++;
    if (reg_wrt !== 4'b0100 || reg_data_out !== 12'hABC) begin
      fails++; $display("FAIL single_T2: got wrt=%b data=%h expected 0100 abc", reg_wrt, reg_data_out);
    end
    tick();  // T+3
    checks++;
    if (reg_wrt !== 4'b0000 || reg_data_out !== 12'hABC) begin
      fails++; $display("FAIL single_T3: got wrt=%b data=%h expected 0000 abc", reg_wrt, reg_data_out);
    end
    tick();  // T+4
    checks++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL single_busy_T4: got %b expected 1", busy);
    end
    tick();
    tick();  // T+6
    checks++;
    if (busy !== 1'b0 || reg_data_out !== 12'hABC || reg_wrt !== 4'b0000) begin
      fails++; $display("FAIL single_T6: got busy=%b data=%h wrt=%b expected 0 abc 0000", busy, reg_data_out, reg_wrt);
    end
  endtask

  task automatic test_burst();
    logic [AW-1:0] addrs [5];
    logic [DW-1:0] datas [5];
    logic [NR-1:0] ew;
    int t0, rel, k;
    addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd1};
    for (int i = 0; i < 5; i++) datas[i] = DW'($urandom);
    apply_reset();
    t0 = cyc + 1;
    for (int r = 0; r < 22; r++) begin
      if (r < 5) begin
        cmd_valid = 1'b1; cmd_addr = addrs[r]; cmd_data = datas[r];
        checks++;
        if (cmd_ready !== 1'b1) begin
          fails++; $display("FAIL burst_ready_before_push%0d: got %b expected 1", r, cmd_ready);
        end
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      rel = cyc - t0;
      if (rel == 4) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          fails++; $display("FAIL burst_full: got cmd_ready=%b expected 0", cmd_ready);
        end
      end
      k  = (rel - 2) / 4;
      ew = (rel >= 2 && (rel - 2) % 4 == 0 && k < 5) ? (NR'(1) << addrs[k]) : '0;
      checks++;
      if (reg_wrt !== ew) begin
        fails++; $display("FAIL burst_wrt rel=%0d: got %b expected %b", rel, reg_wrt, ew);
      end
      if (ew != '0) begin
        checks++;
        if (reg_data_out !== datas[k]) begin
          fails++; $display("FAIL burst_data rel=%0d: got %h expected %h", rel, reg_data_out, datas[k]);
        end
      end
    end
  endtask

  task automatic test_bad_addr();
    apply_reset();
    cmd_valid = 1'b1; cmd_addr = 3'd5; cmd_data = 12'h555;
    tick();
    cmd_valid = 1'b0;
    tick();  // pop of the bad command
    checks++;
    if (err_addr !== 1'b1 || reg_wrt !== 4'b0000 || reg_data_out !== 12'h000) begin
      fails++; $display("FAIL bad_pulse: got err=%b wrt=%b data=%h expected 1 0000 000", err_addr, reg_wrt, reg_data_out);
    end
    tick();
    checks++;
    if (err_addr !== 1'b0 || reg_wrt !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL bad_after: got err=%b wrt=%b busy=%b expected 0 0000 0", err_addr, reg_wrt, busy);
    end
    cmd_valid = 1'b1; cmd_addr = 3'd3; cmd_data = 12'h3C3;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (reg_data_out !== 12'h3C3) begin
      fails++; $display("FAIL bad_next_data: got %h expected 3c3", reg_data_out);
    end
    tick();
    checks++;
    if (reg_wrt !== 4'b1000 || err_addr !== 1'b0) begin
      fails++; $display("FAIL bad_next_wrt: got wrt=%b err=%b expected 1000 0", reg_wrt, err_addr);
    end
  endtask

  task automatic test_settle0();
    logic [AW0-1:0] addrs [3];
    logic [DW-1:0]  datas [3];
    logic [NR-1:0]  ew;
    logic [DW-1:0]  ed;
    int k;
    addrs = '{2'd3, 2'd0, 2'd2};
    datas = '{12'h111, 12'h222, 12'h333};
    apply_reset();
    for (int rel = 0; rel < 8; rel++) begin
      cmd_valid0 = (rel < 3);
      if (rel < 3) begin
        cmd_addr0 = addrs[rel]; cmd_data0 = datas[rel];
      end
      tick();
      if (rel >= 1) begin
        k  = ((rel - 1) / 2 > 2) ? 2 : (rel - 1) / 2;
        ed = datas[k];
        ew = (rel % 2 == 0 && rel <= 6) ? (NR'(1) << addrs[(rel - 2) / 2]) : '0;
        checks++;
        if (reg_wrt0 !== ew || reg_data_out0 !== ed) begin
          fails++; $display("FAIL settle0 rel=%0d: got wrt=%b data=%h expected %b %h", rel, reg_wrt0, reg_data_out0, ew, ed);
        end
      end
    end
    cmd_valid0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_addr = AW'(i); cmd_data = DW'(12'h700 + i);
      tick();
    end
    cmd_valid = 1'b0;
    w = 0;
    while (reg_wrt == '0 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (reg_wrt == '0) begin
      fails++; $display("FAIL midrst_no_strobe: got wrt=%b expected a strobe within 20 cycles", reg_wrt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (reg_wrt !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_drop: got wrt=%b busy=%b expected 0000 0", reg_wrt, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || reg_data_out !== 12'h000) begin
      fails++; $display("FAIL midrst_release: got rdy=%b busy=%b data=%h expected 1 0 000", cmd_ready, busy, reg_data_out);
    end
    w = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (reg_wrt != '0) w++;
    end
    checks++;
    if (w != 0) begin
      fails++; $display("FAIL midrst_queue_flushed: got %0d strobes expected 0", w);
    end
  endtask

`ifdef REG_SHADOW_EN
  task automatic test_shadow();
    logic [AW-1:0] sa [4];
    logic [DW-1:0] sd [4];
    sa = '{3'd1, 3'd3, 3'd0, 3'd5};
    sd = '{12'h123, 12'hFFF, 12'h000, 12'h000};
    apply_reset();
    cmd_valid = 1'b1; cmd_addr = 3'd1; cmd_data = 12'h123;
    tick();
    cmd_addr = 3'd3; cmd_data = 12'hFFF;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 4; i++) begin
      shadow_addr = sa[i];
      #1;
      checks++;
      if (shadow_data !== sd[i]) begin
        fails++; $display("FAIL shadow addr=%0d: got %h expected %h", sa[i], shadow_data, sd[i]);
      end
    end
  endtask
`endif

  // Timing-level model: each accepted command is dispatched at max(accept+1, previous free edge);
  // a good one loads data at dispatch, strobes one edge later and frees the FSM 2+S edges after
  // dispatch; a bad one pulses err_addr at dispatch and frees the FSM one edge later.
  task automatic test_random();
    logic [DW-1:0] exp_data_at [int];
    logic [NR-1:0] exp_wrt_at [int];
    bit            exp_err_at [int];
    int            disp_q [$];
    int            free_at, busy_until, n_acc, n_pop, d;
    logic [DW-1:0] cur_data;
    logic [NR-1:0] ew;
    logic          rdy, ee, er, eb;
    free_at = 0; busy_until = 0; n_acc = 0; n_pop = 0;
    cur_data = '0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = (i < 340) && ($urandom_range(0, 2) != 0);
      cmd_addr  = AW'($urandom_range(0, 5));
      cmd_data  = DW'($urandom);
      rdy = cmd_ready;
      tick();
      if (cmd_valid && rdy) begin
        d = (cyc + 1 > free_at) ? cyc + 1 : free_at;
        disp_q.push_back(d);
        n_acc++;
        if (int'(cmd_addr) < NR) begin
          exp_data_at[d]     = cmd_data;
          exp_wrt_at[d + 1]  = NR'(1) << cmd_addr;
          free_at            = d + 2 + S;
          busy_until         = free_at;
        end else begin
          exp_err_at[d] = 1'b1;
          free_at       = d + 1;
        end
      end
      while (disp_q.size() > 0 && disp_q[0] <= cyc) begin
        void'(disp_q.pop_front());
        n_pop++;
      end
      if (exp_data_at.exists(cyc)) cur_data = exp_data_at[cyc];
      ew = exp_wrt_at.exists(cyc) ? exp_wrt_at[cyc] : '0;
      ee = exp_err_at.exists(cyc);
      er = (n_acc - n_pop) < DEPTH;
      eb = (n_acc - n_pop) > 0 || cyc < busy_until;
      checks++;
      if (reg_wrt !== ew) begin
        fails++; $display("FAIL rnd_wrt cyc=%0d: got %b expected %b", cyc, reg_wrt, ew);
      end
      checks++;
      if (reg_data_out !== cur_data) begin
        fails++; $display("FAIL rnd_data cyc=%0d: got %h expected %h", cyc, reg_data_out, cur_data);
      end
      checks++;
      if (err_addr !== ee) begin
        fails++; $display("FAIL rnd_err cyc=%0d: got %b expected %b", cyc, err_addr, ee);
      end
      checks++;
      if (cmd_ready !== er) begin
        fails++; $display("FAIL rnd_ready cyc=%0d: got %b expected %b", cyc, cmd_ready, er);
      end
      checks++;
      if (busy !== eb) begin
        fails++; $display("FAIL rnd_busy cyc=%0d: got %b expected %b", cyc, busy, eb);
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_random();
    test_single();
    test_burst();
    test_bad_addr();
    test_settle0();
    test_reset_mid();
`ifdef REG_SHADOW_EN
    test_shadow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
